// File: rtl/vector_alu_pipe.sv
// rtl/vector_alu_pipe.sv - two-stage pipelined LANES x BITS vector ALU with valid/ready handshake
// Optional build macro: VALU_SAT_EN selects unsigned saturation for add/sub.
module vector_alu_pipe #(
    parameter int BITS  = 8,
    parameter int ALUOP = 4,
    parameter int LANES = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  inValid,
    output logic                  inReady,
    input  logic [ALUOP-1:0]      aluFunction,
    input  logic [LANES*BITS-1:0] vectorA,
    input  logic [LANES*BITS-1:0] vectorB,
    output logic                  outValid,
    input  logic                  outReady,
    output logic [LANES*BITS-1:0] aluResult,
    output logic [LANES-1:0]      carryFlag,
    output logic [LANES-1:0]      zeroFlag,
    output logic                  illegalOp
);

    localparam int SH = $clog2(BITS);
    localparam int VW = LANES * BITS;

    localparam logic [ALUOP-1:0] OP_MOV   = ALUOP'(1);
    localparam logic [ALUOP-1:0] OP_ADD   = ALUOP'(2);
    localparam logic [ALUOP-1:0] OP_SUB   = ALUOP'(3);
    localparam logic [ALUOP-1:0] OP_XOR   = ALUOP'(4);
    localparam logic [ALUOP-1:0] OP_AND   = ALUOP'(5);
    localparam logic [ALUOP-1:0] OP_OR    = ALUOP'(6);
    localparam logic [ALUOP-1:0] OP_SHL   = ALUOP'(7);
    localparam logic [ALUOP-1:0] OP_SHR   = ALUOP'(8);
    localparam logic [ALUOP-1:0] OP_ROL   = ALUOP'(9);
    localparam logic [ALUOP-1:0] OP_ROR   = ALUOP'(10);
    localparam logic [ALUOP-1:0] OP_BCAST = ALUOP'(11);

    // Returns {carry, result} for one lane.
    function automatic logic [BITS:0] f_lane(
        input logic [ALUOP-1:0] op,
        input logic [BITS-1:0]  a,
        input logic [BITS-1:0]  b,
        input logic [BITS-1:0]  a0
    );
        logic [BITS:0]     wide;
        logic [2*BITS-1:0] dbl;
        logic [BITS-1:0]   res;
        logic              cy;
        logic              big;
        res  = '0;
        cy   = 1'b0;
        wide = '0;
        dbl  = '0;
        // Any set bit above the low SH bits means the amount is >= BITS.
        big  = |(b >> SH);
        case (op)
            OP_MOV: res = a;
            OP_ADD: begin
                wide = {1'b0, a} + {1'b0, b};
                cy   = wide[BITS];
                res  = wide[BITS-1:0];
`ifdef VALU_SAT_EN
                if (cy) res = '1;
`endif
            end
            OP_SUB: begin
                wide = {1'b0, a} - {1'b0, b};
                cy   = wide[BITS];
                res  = wide[BITS-1:0];
`ifdef VALU_SAT_EN
                if (cy) res = '0;
`endif
            end
            OP_XOR: res = a ^ b;
            OP_AND: res = a & b;
            OP_OR:  res = a | b;
            OP_SHL: res = big ? '0 : (a << b);
            OP_SHR: res = big ? '0 : (a >> b);
            OP_ROL: begin
                dbl = {a, a} << b[SH-1:0];
                res = dbl[2*BITS-1:BITS];
            end
            OP_ROR: begin
                dbl = {a, a} >> b[SH-1:0];
                res = dbl[BITS-1:0];
            end
            OP_BCAST: res = a0;
            default:  res = '0;
        endcase
        return {cy, res};
    endfunction

    logic             r_s1_valid;
    logic [ALUOP-1:0] r_s1_op;
    logic [VW-1:0]    r_s1_a;
    logic [VW-1:0]    r_s1_b;

    logic             r_s2_valid;
    logic [VW-1:0]    r_s2_res;
    logic [LANES-1:0] r_s2_carry;
    logic [LANES-1:0] r_s2_zero;
    logic             r_s2_illegal;

    logic             w_s2_load;
    logic             w_s1_load;
    logic [VW-1:0]    w_res;
    logic [LANES-1:0] w_carry;
    logic [LANES-1:0] w_zero;
    logic             w_illegal;

    assign w_s2_load = !r_s2_valid || outReady;
    assign w_s1_load = !r_s1_valid || w_s2_load;
    assign w_illegal = r_s1_op > OP_BCAST;

    genvar g;
    generate
        for (g = 0; g < LANES; g++) begin : g_lane
            logic [BITS:0] w_out;
            assign w_out = f_lane(r_s1_op, r_s1_a[g*BITS +: BITS],
                                  r_s1_b[g*BITS +: BITS], r_s1_a[BITS-1:0]);
            assign w_res[g*BITS +: BITS] = w_out[BITS-1:0];
            assign w_carry[g]            = w_out[BITS];
            assign w_zero[g]             = ~|w_out[BITS-1:0];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_valid   <= 1'b0;
            r_s1_op      <= '0;
            r_s1_a       <= '0;
            r_s1_b       <= '0;
            r_s2_valid   <= 1'b0;
            r_s2_res     <= '0;
            r_s2_carry   <= '0;
            r_s2_zero    <= '0;
            r_s2_illegal <= 1'b0;
        end else begin
            if (w_s1_load) begin
                r_s1_valid <= inValid;
                if (inValid) begin
                    r_s1_op <= aluFunction;
                    r_s1_a  <= vectorA;
                    r_s1_b  <= vectorB;
                end
            end
            // S2 data only changes when a real transaction moves in, so a stalled result holds.
            if (w_s2_load) begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_s2_res     <= w_res;
                    r_s2_carry   <= w_carry;
                    r_s2_zero    <= w_zero;
                    r_s2_illegal <= w_illegal;
                end
            end
        end
    end

    assign inReady   = w_s1_load;
    assign outValid  = r_s2_valid;
    assign aluResult = r_s2_res;
    assign carryFlag = r_s2_carry;
    assign zeroFlag  = r_s2_zero;
    assign illegalOp = r_s2_illegal;

endmodule

// File: tb/tb_vector_alu_pipe.sv
// tb/tb_vector_alu_pipe.sv - self-checking bench for vector_alu_pipe (honours VALU_SAT_EN)
module tb_vector_alu_pipe;

    localparam int BITS  = 8;
    localparam int ALUOP = 4;
    localparam int LANES = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        inValid;
    logic        inReady;
    logic [3:0]  aluFunction;
    logic [31:0] vectorA;
    logic [31:0] vectorB;
    logic        outValid;
    logic        outReady;
    logic [31:0] aluResult;
    logic [3:0]  carryFlag;
    logic [3:0]  zeroFlag;
    logic        illegalOp;

    always #5 clk = ~clk;

    vector_alu_pipe #(.BITS(BITS), .ALUOP(ALUOP), .LANES(LANES)) dut (
        .clk(clk), .reset(reset), .inValid(inValid), .inReady(inReady),
        .aluFunction(aluFunction), .vectorA(vectorA), .vectorB(vectorB),
        .outValid(outValid), .outReady(outReady), .aluResult(aluResult),
        .carryFlag(carryFlag), .zeroFlag(zeroFlag), .illegalOp(illegalOp)
    );

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } req_t;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  carry;
        logic [3:0]  zero;
        logic        ill;
    } rsp_t;

    req_t pend_q[$];
    rsp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   step_no = 0;
    int   last_acc_step = 0;
    int   last_out_step = 0;
    int   first_out_step = 0;
    int   n_acc = 0;
    int   n_out = 0;
    bit   acc_in;
    bit   acc_out;
    rsp_t last_rsp;

    function automatic rsp_t model(input req_t q);
        rsp_t r;
        int a, b, a0, v, k;
        bit c;
        r.res = '0;
        r.carry = '0;
        r.zero = '0;
        a0 = int'(q.a & 32'hFF);
        for (int i = 0; i < 4; i++) begin
            a = int'((q.a >> (8 * i)) & 32'hFF);
            b = int'((q.b >> (8 * i)) & 32'hFF);
            c = 1'b0;
            v = 0;
            case (int'(q.op))
                1:  v = a;
                2: begin
                    c = (a + b) > 255;
                    v = (a + b) % 256;
`ifdef VALU_SAT_EN
                    if (c) v = 255;
`endif
                end
                3: begin
                    c = a < b;
                    v = (a - b + 256) % 256;
`ifdef VALU_SAT_EN
                    if (c) v = 0;
`endif
                end
                4:  v = a ^ b;
                5:  v = a & b;
                6:  v = a | b;
                7:  v = (b >= 8) ? 0 : (a << b) % 256;
                8:  v = (b >= 8) ? 0 : a >> b;
                9: begin
                    k = b % 8;
                    v = ((a << k) | (a >> (8 - k))) % 256;
                end
                10: begin
                    k = b % 8;
                    v = ((a >> k) | (a << (8 - k))) % 256;
                end
                11: v = a0;
                default: v = 0;
            endcase
            r.res[8*i +: 8] = v[7:0];
            r.carry[i] = c;
            r.zero[i] = (v == 0);
        end
        r.ill = (q.op >= 4'd12);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        if (pend_q.size() != 0) begin
            inValid     = 1'b1;
            aluFunction = pend_q[0].op;
            vectorA     = pend_q[0].a;
            vectorB     = pend_q[0].b;
        end else begin
            inValid     = 1'b0;
            aluFunction = 4'($urandom);
            vectorA     = $urandom;
            vectorB     = $urandom;
        end
    endtask

    task automatic step();
        rsp_t e;
        @(negedge clk);
        step_no++;
        acc_in  = inValid && inReady && !reset;
        acc_out = outValid && outReady && !reset;
        if (acc_out) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_output", 64'(outValid), 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("result", 64'(aluResult), 64'(e.res));
                chk("carry", 64'(carryFlag), 64'(e.carry));
                chk("zero", 64'(zeroFlag), 64'(e.zero));
                chk("illegal", 64'(illegalOp), 64'(e.ill));
            end
            last_rsp.res   = aluResult;
            last_rsp.carry = carryFlag;
            last_rsp.zero  = zeroFlag;
            last_rsp.ill   = illegalOp;
            last_out_step  = step_no;
            n_out++;
            if (n_out == 1) first_out_step = step_no;
        end
        if (acc_in) begin
            exp_q.push_back(model(pend_q[0]));
            last_acc_step = step_no;
            n_acc++;
        end
        @(posedge clk);
        #1;
        if (reset) exp_q.delete();
        if (acc_in) void'(pend_q.pop_front());
        drive();
    endtask

    task automatic push(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        req_t q;
        q.op = op;
        q.a  = a;
        q.b  = b;
        pend_q.push_back(q);
    endtask

    task automatic drain(input string tag, input int max_steps);
        int n;
        n = 0;
        while ((pend_q.size() != 0 || exp_q.size() != 0) && n < max_steps) begin
            step();
            n++;
        end
        chk(tag, 64'(pend_q.size() + exp_q.size()), 64'd0);
    endtask

    task automatic run1(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        outReady = 1'b1;
        push(op, a, b);
        drive();
        drain("directed_drain", 20);
    endtask

    initial begin
        int s;
        logic [31:0] rb;
        reset       = 1'b1;
        inValid     = 1'b0;
        outReady    = 1'b0;
        aluFunction = '0;
        vectorA     = '0;
        vectorB     = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outValid", 64'(outValid), 64'd0);
        chk("reset_result", 64'(aluResult), 64'd0);
        chk("reset_carry", 64'(carryFlag), 64'd0);
        chk("reset_zero", 64'(zeroFlag), 64'd0);
        chk("reset_illegal", 64'(illegalOp), 64'd0);
        reset = 1'b0;
        #1;
        chk("reset_inReady", 64'(inReady), 64'd1);

        // Directed cases from the test plan (lane 0 unless noted)
        run1(4'd2, 32'h0000_00F0, 32'h0000_0020);
`ifdef VALU_SAT_EN
        chk("add_sat_res", 64'(last_rsp.res[7:0]), 64'h FF);
`else
        chk("add_wrap_res", 64'(last_rsp.res[7:0]), 64'h10);
`endif
        chk("add_carry0", 64'(last_rsp.carry[0]), 64'd1);
        chk("add_zero0", 64'(last_rsp.zero[0]), 64'd0);

        run1(4'd3, 32'h0000_0005, 32'h0000_0005);
        chk("sub_eq_res", 64'(last_rsp.res[7:0]), 64'h00);
        chk("sub_eq_zero0", 64'(last_rsp.zero[0]), 64'd1);
        chk("sub_eq_carry0", 64'(last_rsp.carry[0]), 64'd0);

        run1(4'd3, 32'h0000_0003, 32'h0000_0004);
`ifdef VALU_SAT_EN
        chk("sub_borrow_res", 64'(last_rsp.res[7:0]), 64'h00);
        chk("sub_borrow_zero0", 64'(last_rsp.zero[0]), 64'd1);
`else
        chk("sub_borrow_res", 64'(last_rsp.res[7:0]), 64'hFF);
`endif
        chk("sub_borrow_carry0", 64'(last_rsp.carry[0]), 64'd1);

        run1(4'd9, 32'h0000_0081, 32'h0000_0009);
        chk("rotl_81_by9", 64'(last_rsp.res[7:0]), 64'h03);
        run1(4'd10, 32'h0000_0081, 32'h0000_0001);
        chk("rotr_81_by1", 64'(last_rsp.res[7:0]), 64'hC0);
        run1(4'd7, 32'h0000_00FF, 32'h0000_0008);
        chk("shl_ff_by8", 64'(last_rsp.res[7:0]), 64'h00);
        run1(4'd8, 32'h0000_0080, 32'h0000_0007);
        chk("shr_80_by7", 64'(last_rsp.res[7:0]), 64'h01);
        run1(4'd11, 32'h4433_2211, 32'h5A5A_5A5A);
        chk("broadcast", 64'(last_rsp.res), 64'h1111_1111);

        run1(4'd13, 32'hDEAD_BEEF, 32'h1234_5678);
        chk("op13_illegal", 64'(last_rsp.ill), 64'd1);
        chk("op13_res", 64'(last_rsp.res), 64'd0);
        chk("op13_zero", 64'(last_rsp.zero), 64'hF);
        chk("op13_carry", 64'(last_rsp.carry), 64'd0);
        run1(4'd0, 32'hDEAD_BEEF, 32'h1234_5678);
        chk("op0_illegal", 64'(last_rsp.ill), 64'd0);
        chk("op0_res", 64'(last_rsp.res), 64'd0);

        // Backpressure: four requests against a stalled consumer
        outReady = 1'b0;
        for (int i = 0; i < 4; i++) push(4'($urandom_range(1, 11)), $urandom, $urandom);
        drive();
        n_acc = 0;
        repeat (5) step();
        chk("bp_accepted", 64'(n_acc), 64'd2);
        chk("bp_inReady_low", 64'(inReady), 64'd0);
        outReady = 1'b1;
        #1;
        chk("bp_release_inReady", 64'(inReady), 64'd1);
        n_out = 0;
        drain("bp_drain", 20);
        chk("bp_outputs", 64'(n_out), 64'd4);
        chk("bp_no_gaps", 64'(last_out_step - first_out_step), 64'd3);

        // Full throughput with outReady held high
        outReady = 1'b1;
        s = step_no;
        for (int i = 0; i < 20; i++) push(4'($urandom_range(0, 15)), $urandom, $urandom);
        drive();
        drain("tput_drain", 100);
        chk("tput_steps", 64'(step_no - s), 64'd22);

        // Reset with two transactions in flight
        outReady = 1'b0;
        push(4'd2, $urandom, $urandom);
        push(4'd4, $urandom, $urandom);
        drive();
        step();
        step();
        reset = 1'b1;
        pend_q.delete();
        step();
        reset = 1'b0;
        drive();
        #1;
        chk("rst_mid_outValid", 64'(outValid), 64'd0);
        chk("rst_mid_result", 64'(aluResult), 64'd0);
        chk("rst_mid_flags", 64'({carryFlag, zeroFlag, illegalOp}), 64'd0);
        chk("rst_mid_inReady", 64'(inReady), 64'd1);
        run1(4'd6, 32'h0F0F_1234, 32'hF000_4321);
        chk("rst_after_latency", 64'(last_out_step - last_acc_step), 64'd2);

        // Randomized traffic with random backpressure
        for (int i = 0; i < 300; i++) begin
            rb = $urandom;
            if ($urandom_range(0, 1) == 1) rb = rb & 32'h0F0F_0F0F;
            push(4'($urandom_range(0, 15)), $urandom, rb);
        end
        drive();
        for (int n = 0; n < 5000 && (pend_q.size() != 0 || exp_q.size() != 0); n++) begin
            outReady = ($urandom_range(0, 3) != 0);
            step();
        end
        outReady = 1'b1;
        drain("random_drain", 20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
